// File: rtl/lut_neuron_table_loader_if.sv
// Host configuration stream and inference lookup port of a runtime-writable LUT neuron.
// master = host/layer side, slave = the table loader.
interface lut_neuron_table_loader_if #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 2
);
    logic                cfg_start;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [OUT_BITS-1:0] cfg_data;
    logic [IN_BITS:0]    cfg_count;
    logic                cfg_done;
    logic                cfg_err;
    logic                tbl_loaded;
    logic [IN_BITS-1:0]  M0;
    logic                M0_valid;
    logic [OUT_BITS-1:0] M1;
    logic                M1_valid;

    modport master (
        output cfg_start, cfg_valid, cfg_data, M0, M0_valid,
        input  cfg_ready, cfg_count, cfg_done, cfg_err, tbl_loaded, M1, M1_valid
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, M0, M0_valid,
        output cfg_ready, cfg_count, cfg_done, cfg_err, tbl_loaded, M1, M1_valid
    );
endinterface

// File: rtl/lut_neuron_table_loader.sv
// Writer side of a LogicNets LUT neuron: streams a 2**IN_BITS-entry truth table into
// distributed RAM, then answers registered lookups once the whole table is present.
module lut_neuron_table_loader #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    lut_neuron_table_loader_if.slave bus
);

    localparam int DEPTH = 2 ** IN_BITS;
    localparam logic [IN_BITS:0] LAST_ADDR = (IN_BITS + 1)'(DEPTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    logic [1:0]          state;
    logic [IN_BITS:0]    count;
    logic                done;
    logic                err;
    logic                loaded;
    logic [OUT_BITS-1:0] lookup_data;
    logic                lookup_valid;
    logic                ready;
    logic                write_en;
    logic                last_beat;

    logic [OUT_BITS-1:0] mem [DEPTH];

    assign ready     = (state == ST_LOAD);
    // A restart in the same cycle as a beat discards the beat.
    assign write_en  = bus.cfg_valid && ready && !bus.cfg_start;
    assign last_beat = write_en && (count == LAST_ADDR);

    // NOTE: every clocked block uses non-blocking assignments so all registers see
    // the pre-edge values of each other, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            count  <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            loaded <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.cfg_start) begin
                        state <= ST_LOAD;
                        count <= '0;
                    end
                end
                ST_LOAD: begin
                    if (bus.cfg_start) begin
                        count <= '0;
                        err   <= 1'b1;
                    end else if (write_en) begin
                        count <= count + 1'b1;
                        if (last_beat) begin
                            state  <= ST_READY;
                            done   <= 1'b1;
                            loaded <= 1'b1;
                            err    <= 1'b0;
                        end
                    end
                end
                ST_READY: begin
                    if (bus.cfg_start) begin
                        state  <= ST_LOAD;
                        count  <= '0;
                        loaded <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the table RAM has no reset; a reset only invalidates it via tbl_loaded,
    // which keeps it mappable onto distributed LUT RAM.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[count[IN_BITS-1:0]] <= bus.cfg_data;
        end
    end

    // Lookups are gated by tbl_loaded, so a read never races a write to the table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookup_data  <= '0;
            lookup_valid <= 1'b0;
        end else begin
            lookup_valid <= bus.M0_valid && loaded;
            if (bus.M0_valid) begin
                lookup_data <= loaded ? mem[bus.M0] : '0;
            end
        end
    end

    assign bus.cfg_ready  = ready;
    assign bus.cfg_count  = count;
    assign bus.cfg_done   = done;
    assign bus.cfg_err    = err;
    assign bus.tbl_loaded = loaded;
    assign bus.M1         = lookup_data;
    assign bus.M1_valid   = lookup_valid;

endmodule

// File: tb/tb_lut_neuron_table_loader.sv
// Randomized bench for lut_neuron_table_loader against a table-level reference model.
module tb_lut_neuron_table_loader;

    localparam int IN_BITS  = 6;
    localparam int OUT_BITS = 2;
    localparam int DEPTH    = 2 ** IN_BITS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lut_neuron_table_loader_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) bus ();

    lut_neuron_table_loader #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference table: entry i holds the data of the i-th accepted beat of a load.
    logic [OUT_BITS-1:0] model_mem [DEPTH];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;
        bus.M0        = '0;
        bus.M0_valid  = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
    endtask

    function automatic logic [OUT_BITS-1:0] beat_data(input int mode, input int idx);
        case (mode)
            0:       return OUT_BITS'(idx % 4);
            1:       return 2'b11;
            default: return OUT_BITS'($urandom);
        endcase
    endfunction

    task automatic check_zero_outputs(input string tag);
        n_checks++;
        if ({bus.cfg_ready, bus.cfg_count, bus.cfg_done, bus.cfg_err, bus.tbl_loaded, bus.M1, bus.M1_valid} !== '0) begin
            n_fail++;
            $display("FAIL %s: ready=%b count=%0d done=%b err=%b loaded=%b M1=%b M1_valid=%b, all required 0",
                     tag, bus.cfg_ready, bus.cfg_count, bus.cfg_done, bus.cfg_err, bus.tbl_loaded, bus.M1, bus.M1_valid);
        end
    endtask

    // Streams n beats into an active load; every valid beat must be accepted, the count
    // must follow the accepted beats and cfg_done must appear only after beat DEPTH.
    task automatic load_beats(input int n, input int gap_pct, input int mode, input string tag);
        int idx = 0;
        int cycles = 0;
        logic v;
        logic exp_done;
        logic [OUT_BITS-1:0] d;
        while (idx < n && cycles < 5000) begin
            v = ($urandom_range(99) >= gap_pct);
            d = beat_data(mode, idx);
            bus.cfg_valid = v;
            bus.cfg_data  = d;
            tick();
            cycles++;
            if (v) begin
                model_mem[idx] = d;
                idx++;
            end
            exp_done = v && (idx == DEPTH);
            n_checks++;
            if (bus.cfg_count !== (IN_BITS + 1)'(idx)) begin
                n_fail++;
                $display("FAIL %s count: got %0d expected %0d", tag, bus.cfg_count, idx);
            end
            n_checks++;
            if (bus.cfg_done !== exp_done) begin
                n_fail++;
                $display("FAIL %s done: got %b expected %b at beat %0d", tag, bus.cfg_done, exp_done, idx);
            end
            n_checks++;
            if (bus.cfg_ready !== (idx < DEPTH)) begin
                n_fail++;
                $display("FAIL %s ready: got %b expected %b at beat %0d", tag, bus.cfg_ready, idx < DEPTH, idx);
            end
        end
        bus.cfg_valid = 1'b0;
    endtask

    task automatic check_loaded_state(input string tag);
        n_checks++;
        if ({bus.cfg_count, bus.tbl_loaded, bus.cfg_err, bus.cfg_ready} !== {7'(DEPTH), 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s completion: count=%0d loaded=%b err=%b ready=%b, required 64/1/0/0",
                     tag, bus.cfg_count, bus.tbl_loaded, bus.cfg_err, bus.cfg_ready);
        end
        tick();
        n_checks++;
        if (bus.cfg_done !== 1'b0 || bus.tbl_loaded !== 1'b1) begin
            n_fail++;
            $display("FAIL %s after done: done=%b loaded=%b, required 0/1", tag, bus.cfg_done, bus.tbl_loaded);
        end
    endtask

    task automatic lookup_all(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            bus.M0       = IN_BITS'(a);
            bus.M0_valid = 1'b1;
            tick();
            n_checks++;
            if (bus.M1 !== model_mem[a] || bus.M1_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL %s lookup[%0d]: M1=%b valid=%b, required M1=%b valid=1",
                         tag, a, bus.M1, bus.M1_valid, model_mem[a]);
            end
        end
        bus.M0_valid = 1'b0;
        bus.M0       = '0;
        tick();
        n_checks++;
        if (bus.M1 !== model_mem[DEPTH-1] || bus.M1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s hold: M1=%b valid=%b, required M1=%b valid=0", tag, bus.M1, bus.M1_valid, model_mem[DEPTH-1]);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        check_zero_outputs("reset_release");
        pulse_start();
        load_beats(5, 0, 2, "reset_preload");
        #3;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("reset_async_assert");
        tick();
        rst_n = 1'b1;
        tick();
        check_zero_outputs("reset_after_release");
    endtask

    task automatic test_full_load();
        pulse_start();
        n_checks++;
        if (bus.cfg_ready !== 1'b1 || bus.cfg_count !== '0 || bus.tbl_loaded !== 1'b0) begin
            n_fail++;
            $display("FAIL full_load start: ready=%b count=%0d loaded=%b, required 1/0/0",
                     bus.cfg_ready, bus.cfg_count, bus.tbl_loaded);
        end
        load_beats(DEPTH, 0, 0, "full_load");
        check_loaded_state("full_load");
        bus.M0       = 6'h25;
        bus.M0_valid = 1'b1;
        tick();
        bus.M0_valid = 1'b0;
        n_checks++;
        if (bus.M1 !== 2'b01 || bus.M1_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_load lookup 0x25: M1=%b valid=%b, required 01/1", bus.M1, bus.M1_valid);
        end
    endtask

    task automatic test_gaps();
        pulse_start();
        n_checks++;
        if (bus.tbl_loaded !== 1'b0 || bus.cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL gaps restart from ready: loaded=%b err=%b, required 0/0", bus.tbl_loaded, bus.cfg_err);
        end
        load_beats(DEPTH, 40, 0, "gaps");
        check_loaded_state("gaps");
        lookup_all("gaps");
    endtask

    task automatic test_abort();
        pulse_start();
        load_beats(10, 0, 2, "abort_pre");
        bus.cfg_start = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 2'b10;
        tick();
        idle_inputs();
        n_checks++;
        if (bus.cfg_err !== 1'b1 || bus.cfg_count !== '0 || bus.cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort: err=%b count=%0d ready=%b, required 1/0/1", bus.cfg_err, bus.cfg_count, bus.cfg_ready);
        end
        tick();
        tick();
        n_checks++;
        if (bus.cfg_err !== 1'b1 || bus.cfg_count !== '0) begin
            n_fail++;
            $display("FAIL abort sticky: err=%b count=%0d, required 1/0", bus.cfg_err, bus.cfg_count);
        end
        load_beats(DEPTH, 30, 1, "abort_reload");
        check_loaded_state("abort_reload");
        lookup_all("abort_reload");
    endtask

    task automatic test_gating();
        apply_reset();
        bus.M0_valid  = 1'b1;
        bus.M0        = IN_BITS'($urandom);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_zero_outputs("gating_idle");
        end
        idle_inputs();
        pulse_start();
        load_beats(DEPTH, 10, 0, "gating_load");
        check_loaded_state("gating_load");
        bus.M0       = 6'd1;
        bus.M0_valid = 1'b1;
        tick();
        bus.M0_valid = 1'b0;
        n_checks++;
        if (bus.M1 !== 2'b01 || bus.M1_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL gating ready lookup: M1=%b valid=%b, required 01/1", bus.M1, bus.M1_valid);
        end
        pulse_start();
        n_checks++;
        if (bus.tbl_loaded !== 1'b0) begin
            n_fail++;
            $display("FAIL gating loaded after restart: got %b required 0", bus.tbl_loaded);
        end
        load_beats(20, 10, 2, "gating_partial");
        bus.M0       = 6'd1;
        bus.M0_valid = 1'b1;
        tick();
        bus.M0_valid = 1'b0;
        n_checks++;
        if (bus.M1 !== 2'b00 || bus.M1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL gating during load: M1=%b valid=%b, required 00/0", bus.M1, bus.M1_valid);
        end
    endtask

    task automatic test_reset_mid_load();
        apply_reset();
        pulse_start();
        load_beats(30, 20, 2, "midreset_pre");
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset_assert");
        tick();
        rst_n = 1'b1;
        tick();
        check_zero_outputs("midreset_release");
        pulse_start();
        load_beats(DEPTH, 25, 2, "midreset_reload");
        check_loaded_state("midreset_reload");
        lookup_all("midreset_reload");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_full_load();
        test_gaps();
        test_abort();
        test_gating();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
